// File: rtl/ladybird_axi_line_master_pkg.sv
// Shared AXI constants and helpers for the ladybird line master and its bus interface.
package ladybird_axi_line_master_pkg;

  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Number of data beats needed to move one cache line.
  function automatic int beats_of(input int line_bytes, input int data_w);
    return (line_bytes * 8) / data_w;
  endfunction

endpackage

// File: rtl/ladybird_axi_interface.sv
// AXI4 channel bundle (AW/W/B/AR/R) with master and slave views.
interface ladybird_axi_interface #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 4
);
  import ladybird_axi_line_master_pkg::*;

  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [LEN_W-1:0]        awlen;
  logic [SIZE_W-1:0]       awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [LEN_W-1:0]        arlen;
  logic [SIZE_W-1:0]       arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/ladybird_axi_line_master.sv
// Whole-line AXI master: turns one cache line refill or write-back into a single INCR burst
// and hands the line and an error flag back to the requester.
module ladybird_axi_line_master
  import ladybird_axi_line_master_pkg::*;
#(
  parameter int LINE_BYTES = 32,
  parameter int AXI_ID     = 0,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AXI_ADDR_W-1:0]   req_addr,
  input  logic [LINE_BYTES*8-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [LINE_BYTES*8-1:0] rsp_rdata,
  output logic                    rsp_error,
  ladybird_axi_interface.master   axi
);

  localparam int BEATS  = beats_of(LINE_BYTES, AXI_DATA_W);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BEAT_W = $clog2(BEATS) + 1;
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LEN_W-1:0]    AX_LEN    = LEN_W'(BEATS - 1);
  localparam logic [SIZE_W-1:0]   AX_SIZE   = SIZE_W'($clog2(AXI_DATA_W / 8));
  localparam logic [AXI_ID_W-1:0] AX_ID     = AXI_ID_W'(AXI_ID);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_RESP = 3'd6
  } state_t;

  state_t                  r_state;
  logic [AXI_ADDR_W-1:0]   r_addr;
  logic [AXI_DATA_W-1:0]   r_line [BEATS];
  logic [BEAT_W-1:0]       r_beat;
  logic                    r_arvalid;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_wlast;
  logic                    r_rready;
  logic                    r_bready;
  logic                    r_rsp_valid;
  logic                    r_rsp_error;

  logic [IDX_W-1:0]        w_idx;
  logic [BEAT_W-1:0]       w_beat_nxt;
  logic                    w_last_beat;
  logic                    w_unused;

  assign w_idx       = r_beat[IDX_W-1:0];
  assign w_beat_nxt  = r_beat + BEAT_W'(1);
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_unused    = ^{axi.rresp, axi.bresp, axi.rid, req_addr[OFF_W-1:0]};

  // Transaction sequencer: one line in flight, every handshake output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= {AXI_ADDR_W{1'b0}};
      r_beat      <= {BEAT_W{1'b0}};
      r_arvalid   <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_rready    <= 1'b0;
      r_bready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      for (int b = 0; b < BEATS; b++) r_line[b] <= {AXI_DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= {req_addr[AXI_ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_rsp_error <= 1'b0;
            // Refills start from a clean buffer so a short burst never leaks old data.
            for (int b = 0; b < BEATS; b++)
              r_line[b] <= req_write ? req_wdata[b*AXI_DATA_W +: AXI_DATA_W] : {AXI_DATA_W{1'b0}};
            if (req_write) begin
              r_awvalid <= 1'b1;
              r_state   <= S_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= {BEAT_W{1'b0}};
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (axi.rvalid) begin
            r_line[w_idx] <= axi.rdata;
            r_beat        <= w_beat_nxt;
            if (w_last_beat != axi.rlast) r_rsp_error <= 1'b1;
            if (w_last_beat || axi.rlast) begin
              r_rready    <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_AW: begin
          if (axi.awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (BEATS == 1);
            r_beat    <= {BEAT_W{1'b0}};
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (axi.wready) begin
            if (w_last_beat) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_B;
            end else begin
              r_beat  <= w_beat_nxt;
              r_wlast <= (w_beat_nxt == LAST_BEAT);
            end
          end
        end
        S_B: begin
          if (axi.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (axi.bid != AX_ID) r_rsp_error <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_arvalid   <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_wlast     <= 1'b0;
          r_rready    <= 1'b0;
          r_bready    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_pack
    assign rsp_rdata[b*AXI_DATA_W +: AXI_DATA_W] = r_line[b];
  end

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_error   = r_rsp_error;

  assign axi.awid    = AX_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = AX_LEN;
  assign axi.awsize  = AX_SIZE;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = r_awvalid;
  assign axi.wdata   = r_line[w_idx];
  assign axi.wstrb   = {(AXI_DATA_W/8){1'b1}};
  assign axi.wlast   = r_wlast;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;
  assign axi.arid    = AX_ID;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = AX_LEN;
  assign axi.arsize  = AX_SIZE;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

endmodule

// File: tb/tb_ladybird_axi_line_master.sv
// Bench for the line master: randomized AXI slave with stalls, line-level reference memory,
// and a per-cycle compare process against that reference.
module tb_ladybird_axi_line_master;

  localparam int BEATS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr  = 32'h0;
  logic [255:0] req_wdata = 256'h0;
  logic         rsp_ready = 1'b0;
  logic         req_ready;
  logic         rsp_valid;
  logic         rsp_error;
  logic [255:0] rsp_rdata;

  ladybird_axi_interface #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(4)) axi ();

  ladybird_axi_line_master #(
    .LINE_BYTES(32), .AXI_ID(0), .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_ID_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Per-transaction slave behaviour: 0 normal, k>0 rlast on beat k-1, -1 rlast never sent.
  int          cfg_rlast_at = 0;
  logic [3:0]  cfg_bid      = 4'd0;
  bit          hold5        = 1'b0;

  // Reference model state (line granularity).
  bit [255:0]  ref_mem [bit [31:0]];
  bit          m_idle = 1'b1;
  bit          m_acc_pulse = 1'b0;
  bit          m_write;
  bit [31:0]   m_addr;
  bit [255:0]  m_line;
  bit [255:0]  m_mask;
  bit          m_exp_err;
  bit          m_rsp_open = 1'b0;
  logic [255:0] snap_rdata;
  logic         snap_err;
  int           rsp_cycles;
  logic [255:0] last_rdata;
  logic         last_err;
  int           last_rsp_cycles;

  // Compare process: checks DUT outputs against the reference every negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_idle      = 1'b1;
        m_acc_pulse = 1'b0;
        m_rsp_open  = 1'b0;
      end else begin
        chk("req_ready", req_ready, m_idle);
        if (m_idle) chk("rsp_valid_idle", rsp_valid, 1'b0);
        if (m_acc_pulse) begin
          chk("arvalid_issue", axi.arvalid, !m_write);
          chk("awvalid_issue", axi.awvalid, m_write);
          m_acc_pulse = 1'b0;
        end
        if (m_rsp_open) chk("rsp_valid_held", rsp_valid, 1'b1);
        if (rsp_valid) begin
          chk("rready_in_resp", axi.rready, 1'b0);
          chk("bready_in_resp", axi.bready, 1'b0);
          if (!m_rsp_open) begin
            m_rsp_open = 1'b1;
            rsp_cycles = 0;
            snap_rdata = rsp_rdata;
            snap_err   = rsp_error;
            chk("rsp_error", rsp_error, m_exp_err);
            if (!m_write) chk("rsp_rdata", rsp_rdata & m_mask, m_line & m_mask);
          end else begin
            chk("rsp_rdata_stable", rsp_rdata, snap_rdata);
            chk("rsp_error_stable", rsp_error, snap_err);
          end
          rsp_cycles++;
          if (rsp_ready) begin
            m_rsp_open      = 1'b0;
            last_rdata      = rsp_rdata;
            last_err        = rsp_error;
            last_rsp_cycles = rsp_cycles;
            if (m_write) ref_mem[m_addr] = m_line;
            m_idle = 1'b1;
          end
        end
        if (req_valid && req_ready) begin
          int words;
          m_write   = req_write;
          m_addr    = {req_addr[31:5], 5'b0};
          m_line    = req_write ? req_wdata : (ref_mem.exists(m_addr) ? ref_mem[m_addr] : 256'h0);
          m_exp_err = req_write ? (cfg_bid != 4'd0) : (cfg_rlast_at != 0);
          words     = (!req_write && cfg_rlast_at > 0) ? cfg_rlast_at : BEATS;
          m_mask    = 256'h0;
          for (int b = 0; b < BEATS; b++) if (b < words) m_mask[b*32 +: 32] = 32'hFFFF_FFFF;
          m_idle      = 1'b0;
          m_acc_pulse = 1'b1;
        end
      end
    end
  end

  // Simulation slave: word memory, random ready/valid stalls.
  bit [31:0]   smem [bit [31:0]];
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  bit          s_wopen, s_bpend, s_rpend, s_wlast_seen;
  bit [31:0]   s_waddr, s_raddr;
  int          s_wcnt, s_rcnt, s_rstop;
  logic [31:0] last_awaddr, last_araddr;
  logic [7:0]  last_awlen, last_arlen;
  logic [2:0]  last_awsize;
  int          last_wbeats;

  function automatic bit [31:0] word_at(input bit [31:0] a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction

  task automatic slave_clear();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = 4'd0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rid = 4'd0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rdata = 32'h0;
    hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0; hs_ar = 1'b0; hs_r = 1'b0;
    s_wopen = 1'b0; s_bpend = 1'b0; s_rpend = 1'b0; s_wcnt = 0; s_rcnt = 0;
  endtask

  // Slave process: retire last edge's handshakes, pick new outputs, predict next edge's handshakes.
  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_clear();
      end else begin
        if (hs_aw) begin s_wcnt = 0; s_wopen = 1'b1; end
        if (hs_w) begin
          s_wcnt++;
          if (s_wlast_seen) begin s_wopen = 1'b0; s_bpend = 1'b1; end
        end
        if (hs_b) axi.bvalid = 1'b0;
        if (hs_ar) begin s_rcnt = 0; s_rpend = 1'b1; s_rstop = (cfg_rlast_at > 0) ? cfg_rlast_at : BEATS; end
        if (hs_r) begin
          axi.rvalid = 1'b0;
          s_rcnt++;
          if (s_rcnt == s_rstop) s_rpend = 1'b0;
        end
        axi.awready = ($urandom_range(0, 2) != 0);
        axi.wready  = ($urandom_range(0, 2) != 0);
        axi.arready = ($urandom_range(0, 2) != 0);
        if (s_bpend && !axi.bvalid && $urandom_range(0, 2) != 0) begin
          axi.bvalid = 1'b1; axi.bid = cfg_bid; s_bpend = 1'b0;
        end
        if (s_rpend && !axi.rvalid && $urandom_range(0, 2) != 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = word_at(s_raddr + 32'(4 * s_rcnt));
          axi.rlast  = (cfg_rlast_at >= 0) && (s_rcnt == s_rstop - 1);
        end
        if (s_wopen) chk("wvalid_held", axi.wvalid, 1'b1);

        hs_aw = axi.awvalid && axi.awready;
        if (hs_aw) begin
          chk("awaddr", axi.awaddr, m_addr);
          chk("awlen", axi.awlen, 8'd7);
          chk("awsize", axi.awsize, 3'd2);
          chk("awburst", axi.awburst, 2'b01);
          chk("awid", axi.awid, 4'd0);
          s_waddr = axi.awaddr; last_awaddr = axi.awaddr; last_awlen = axi.awlen; last_awsize = axi.awsize;
        end
        hs_w = axi.wvalid && axi.wready;
        if (hs_w) begin
          chk("w_in_burst", (s_wcnt < BEATS), 1'b1);
          chk("wdata", axi.wdata, m_line[(s_wcnt % BEATS)*32 +: 32]);
          chk("wstrb", axi.wstrb, 4'hF);
          chk("wlast", axi.wlast, (s_wcnt == BEATS - 1));
          smem[s_waddr + 32'(4 * s_wcnt)] = axi.wdata;
          s_wlast_seen = axi.wlast;
        end
        hs_b = axi.bvalid && axi.bready;
        if (hs_b) begin
          chk("w_beat_count", s_wcnt, BEATS);
          last_wbeats = s_wcnt;
        end
        hs_ar = axi.arvalid && axi.arready;
        if (hs_ar) begin
          chk("araddr", axi.araddr, m_addr);
          chk("arlen", axi.arlen, 8'd7);
          chk("arsize", axi.arsize, 3'd2);
          chk("arburst", axi.arburst, 2'b01);
          chk("arid", axi.arid, 4'd0);
          s_raddr = axi.araddr; last_araddr = axi.araddr; last_arlen = axi.arlen;
        end
        hs_r = axi.rvalid && axi.rready;
      end
    end
  end

  // Response consumer: random back-pressure, or exactly five stall cycles when hold5 is set.
  initial begin
    int sc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rsp_valid) sc = 0;
      if (hold5 && rsp_valid && sc < 5) begin
        rsp_ready = 1'b0;
        sc++;
      end else begin
        rsp_ready = (hold5 && rsp_valid) ? 1'b1 : ($urandom_range(0, 1) == 1);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d);
    int   budget = 0;
    logic rdy;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) break;
      budget++;
      if (budget > 3000) begin bound_fail("issue_accept"); break; end
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (!m_idle && budget < 3000);
    if (!m_idle) bound_fail("wait_idle");
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int b = 0; b < BEATS; b++) v[b*32 +: 32] = $urandom();
    return v;
  endfunction

  localparam logic [255:0] BYTES_0_31 =
    256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;

  initial begin
    logic [255:0] d;
    int budget;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_wlast", axi.wlast, 1'b0);
    chk("rst_rready", axi.rready, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 256'h0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i);
    issue(1'b1, 32'h8000_0020, d);
    wait_idle();
    chk("dir_awaddr", last_awaddr, 32'h8000_0020);
    chk("dir_awlen", last_awlen, 8'd7);
    chk("dir_awsize", last_awsize, 3'd2);
    chk("dir_wbeats", last_wbeats, 8);
    chk("dir_wr_err", last_err, 1'b0);

    issue(1'b0, 32'h8000_0025, 256'h0);
    wait_idle();
    chk("dir_araddr", last_araddr, 32'h8000_0020);
    chk("dir_arlen", last_arlen, 8'd7);
    chk("dir_rdata", last_rdata, BYTES_0_31);
    chk("dir_rd_err", last_err, 1'b0);

    hold5 = 1'b1;
    issue(1'b0, 32'h8000_0020, 256'h0);
    wait_idle();
    hold5 = 1'b0;
    chk("hold5_cycles", last_rsp_cycles, 6);
    chk("hold5_rdata", last_rdata, BYTES_0_31);

    for (int k = 0; k < 4; k++) issue(1'b1, 32'h8000_1000 + 32'(k * 32), rand_line());
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'h8000_1000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) issue(1'b1, a, rand_line());
      else issue(1'b0, a, 256'h0);
    end
    wait_idle();

    cfg_rlast_at = 4;
    issue(1'b0, 32'h8000_0020, 256'h0);
    wait_idle();
    cfg_rlast_at = 0;
    chk("early_rlast_err", last_err, 1'b1);
    chk("early_rlast_beats", s_rcnt, 4);
    chk("early_rlast_low", last_rdata[127:0], BYTES_0_31[127:0]);

    cfg_rlast_at = -1;
    issue(1'b0, 32'h8000_0020, 256'h0);
    wait_idle();
    cfg_rlast_at = 0;
    chk("no_rlast_err", last_err, 1'b1);
    chk("no_rlast_beats", s_rcnt, 8);

    cfg_bid = 4'd3;
    issue(1'b1, 32'h8000_3000, rand_line());
    wait_idle();
    cfg_bid = 4'd0;
    chk("bad_bid_err", last_err, 1'b1);

    issue(1'b1, 32'h8000_4000, rand_line());
    budget = 0;
    do begin
      @(negedge clk);
      #2;
      budget++;
    end while (!(s_wopen && s_wcnt == 4) && budget < 3000);
    if (!(s_wopen && s_wcnt == 4)) bound_fail("reach_w_beat4");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midw_rst_wvalid", axi.wvalid, 1'b0);
    chk("midw_rst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(1'b0, 32'h8000_0020, 256'h0);
    wait_idle();
    chk("post_rst_err", last_err, 1'b0);
    chk("post_rst_rdata", last_rdata, BYTES_0_31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
